// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode with valid/ready handshake,
// register scoreboard (RAW/WAW stall), flush and illegal-opcode flagging
module decode_stage #(
   parameter  int RA_W    = 4,
   parameter  int JADDR_W = 6,
   localparam int INSTR_W = 4 + 3*RA_W + 2,
   localparam int DATA_W  = 2*RA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         alu_op,
   output logic [RA_W-1:0]    src0,
   output logic [RA_W-1:0]    src1,
   output logic [RA_W-1:0]    dst,
   output logic [DATA_W-1:0]  data,
   output logic [JADDR_W-1:0] jmp_addr,
   output logic               sel1,
   output logic               sel2,
   output logic               reg_we,
   output logic               mem_we,
   output logic               is_branch,
   output logic               illegal,
   input  logic               wb_valid,
   input  logic [RA_W-1:0]    wb_dst,
   output logic               busy
);

   localparam int NREG = 2**RA_W;

   localparam logic [3:0] OP_ADD        = 4'h0;
   localparam logic [3:0] OP_SUB        = 4'h1;
   localparam logic [3:0] OP_MUL        = 4'h2;
   localparam logic [3:0] OP_CHECK      = 4'h3;
   localparam logic [3:0] OP_SUPERCHECK = 4'h4;
   localparam logic [3:0] OP_INC        = 4'h5;
   localparam logic [3:0] OP_DEC        = 4'h6;
   localparam logic [3:0] OP_JUMP       = 4'h7;
   localparam logic [3:0] OP_LOADIN     = 4'h8;
   localparam logic [3:0] OP_STORE      = 4'h9;
   localparam logic [3:0] OP_LOAD       = 4'hA;

   typedef struct packed {
      logic [3:0]         alu_op;
      logic [RA_W-1:0]    src0;
      logic [RA_W-1:0]    src1;
      logic [RA_W-1:0]    dst;
      logic [DATA_W-1:0]  data;
      logic [JADDR_W-1:0] jmp_addr;
      logic               sel1;
      logic               sel2;
      logic               reg_we;
      logic               mem_we;
      logic               is_branch;
      logic               illegal;
   } dec_t;

   logic [3:0]        f_opc;
   logic [RA_W-1:0]   f_a;
   logic [RA_W-1:0]   f_b;
   logic [RA_W-1:0]   f_c;
   logic [1:0]        f_t;
   logic [RA_W+1:0]   f_ct;
   logic [2*RA_W-1:0] f_ab;

   dec_t            d;
   dec_t            q;
   logic            rd_a;
   logic            rd_b;
   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_next;
   logic [NREG-1:0] wb_mask;
   logic [NREG-1:0] pend;
   logic            hazard;
   logic            accept;
   logic            drop_held;

   assign {f_opc, f_a, f_b, f_c, f_t} = in_instr;
   assign f_ct = {f_c, f_t};
   assign f_ab = {f_a, f_b};

   always_comb begin
      d    = '0;
      rd_a = 1'b0;
      rd_b = 1'b0;
      case (f_opc)
         OP_ADD, OP_SUB, OP_MUL: begin
            d.alu_op = f_opc;
            d.src0   = f_a;
            d.src1   = f_b;
            d.dst    = f_c;
            d.sel1   = 1'b1;
            d.reg_we = 1'b1;
            rd_a     = 1'b1;
            rd_b     = 1'b1;
         end
         OP_CHECK, OP_SUPERCHECK: begin
            d.alu_op    = f_opc;
            d.src0      = f_a;
            d.src1      = f_b;
            d.jmp_addr  = f_ct[JADDR_W-1:0];
            d.sel1      = 1'b1;
            d.is_branch = 1'b1;
            rd_a        = 1'b1;
            rd_b        = 1'b1;
         end
         OP_INC, OP_DEC: begin
            d.alu_op = f_opc;
            d.src0   = f_a;
            d.dst    = f_c;
            d.sel1   = 1'b1;
            d.reg_we = 1'b1;
            rd_a     = 1'b1;
         end
         OP_JUMP: begin
            d.alu_op    = f_opc;
            d.jmp_addr  = f_ab[2*RA_W-1 -: JADDR_W];
            d.is_branch = 1'b1;
         end
         OP_LOADIN: begin
            d.alu_op = f_opc;
            d.data   = f_ab;
            d.dst    = f_c;
            d.reg_we = 1'b1;
         end
         OP_STORE: begin
            d.alu_op = f_opc;
            d.src0   = f_a;
            d.src1   = f_b;
            d.sel1   = 1'b1;
            d.mem_we = 1'b1;
            rd_a     = 1'b1;
            rd_b     = 1'b1;
         end
         OP_LOAD: begin
            d.alu_op = f_opc;
            d.src1   = f_b;
            d.dst    = f_c;
            d.sel2   = 1'b1;
            d.reg_we = 1'b1;
            rd_b     = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
   end

   // A write-back in the same cycle already releases the register for hazard purposes
   always_comb begin
      wb_mask = '0;
      if (wb_valid) wb_mask[wb_dst] = 1'b1;
   end

   assign pend   = sb & ~wb_mask;
   assign hazard = in_valid & ((rd_a & pend[f_a]) | (rd_b & pend[f_b]) | (d.reg_we & pend[f_c]));
   assign in_ready  = (~out_valid | out_ready) & ~hazard & ~flush;
   assign accept    = in_valid & in_ready;
   assign drop_held = flush & out_valid & ~out_ready & q.reg_we;

   // A new reservation is applied last so it wins over a same-index write-back
   always_comb begin
      sb_next = pend;
      if (drop_held) sb_next[q.dst] = 1'b0;
      if (accept && d.reg_we) sb_next[f_c] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb        <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         q         <= '0;
      end else begin
         sb   <= sb_next;
         busy <= |sb_next;
         if (flush) begin
            out_valid <= 1'b0;
            q         <= '0;
         end else if (accept) begin
            out_valid <= 1'b1;
            q         <= d;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            q         <= '0;
         end
      end
   end

   assign alu_op    = q.alu_op;
   assign src0      = q.src0;
   assign src1      = q.src1;
   assign dst       = q.dst;
   assign data      = q.data;
   assign jmp_addr  = q.jmp_addr;
   assign sel1      = q.sel1;
   assign sel2      = q.sel2;
   assign reg_we    = q.reg_we;
   assign mem_we    = q.mem_we;
   assign is_branch = q.is_branch;
   assign illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage: vector table,
// hand-written handshake/hazard/flush/reset sequences and a randomized reference-model run
module tb_decode_stage;
   localparam int RA_W    = 4;
   localparam int JADDR_W = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] in_instr = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  alu_op;
   logic [3:0]  src0, src1, dst;
   logic [7:0]  data;
   logic [5:0]  jmp_addr;
   logic        sel1, sel2, reg_we, mem_we, is_branch, illegal;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_dst = '0;
   logic        busy;

   decode_stage #(.RA_W(RA_W), .JADDR_W(JADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .src0(src0), .src1(src1), .dst(dst), .data(data),
      .jmp_addr(jmp_addr), .sel1(sel1), .sel2(sel2), .reg_we(reg_we), .mem_we(mem_we),
      .is_branch(is_branch), .illegal(illegal), .wb_valid(wb_valid), .wb_dst(wb_dst),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [3:0] src0;
      logic [3:0] src1;
      logic [3:0] dst;
      logic [7:0] data;
      logic [5:0] jmp;
      logic       sel1, sel2, reg_we, mem_we, is_branch, illegal;
   } fields_t;

   typedef struct {
      logic [17:0] instr;
      fields_t     exp;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] mk(input int op, input int a, input int b, input int c, input int t);
      logic [17:0] w;
      w = {op[3:0], a[3:0], b[3:0], c[3:0], t[1:0]};
      return w;
   endfunction

   // flags = {sel1, sel2, reg_we, mem_we, is_branch, illegal}
   function automatic fields_t ex(input int op, input int s0, input int s1, input int d,
                                  input int dat, input int j, input int fl);
      fields_t f;
      f = {op[3:0], s0[3:0], s1[3:0], d[3:0], dat[7:0], j[5:0], fl[5:0]};
      return f;
   endfunction

   function automatic fields_t observed();
      return {alu_op, src0, src1, dst, data, jmp_addr, sel1, sel2, reg_we, mem_we, is_branch, illegal};
   endfunction

   // Reference decode from opcode classes: which fields an opcode reads/writes
   function automatic void ref_dec(input logic [17:0] w, output fields_t f,
                                   output logic ra, output logic rb, output logic wc);
      int op, a, b, c, t;
      op = int'(w[17:14]); a = int'(w[13:10]); b = int'(w[9:6]); c = int'(w[5:2]); t = int'(w[1:0]);
      f = '0; ra = 1'b0; rb = 1'b0; wc = 1'b0;
      if (op > 10) begin
         f.illegal = 1'b1;
         return;
      end
      f.alu_op = 4'(op);
      ra = op inside {0, 1, 2, 3, 4, 5, 6, 9};
      rb = op inside {0, 1, 2, 3, 4, 9, 10};
      wc = op inside {0, 1, 2, 5, 6, 8, 10};
      if (ra) f.src0 = 4'(a);
      if (rb) f.src1 = 4'(b);
      if (wc) begin
         f.dst    = 4'(c);
         f.reg_we = 1'b1;
      end
      f.sel1      = ra;
      f.sel2      = (op == 10);
      f.mem_we    = (op == 9);
      f.is_branch = op inside {3, 4, 7};
      if (op == 3 || op == 4) f.jmp = 6'(c * 4 + t);
      if (op == 7) f.jmp = 6'((a * 16 + b) >> 2);
      if (op == 8) f.data = 8'(a * 16 + b);
   endfunction

   task automatic clear_reg(input int r);
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_dst = 4'(r);
      @(posedge clk); #1;
      wb_valid = 1'b0;
   endtask

   vec_t    vecs[13];
   fields_t mf;
   logic    mra, mrb, mwc;
   logic    m_valid;
   fields_t m_out;
   logic    m_pend[16];
   int      jexp[8];

   initial begin
      vecs[0]  = '{instr: mk(0, 1, 2, 3, 0),      exp: ex(0, 1, 2, 3, 0, 0, 'b101000)};
      vecs[1]  = '{instr: mk(3, 4, 5, 10, 2),     exp: ex(3, 4, 5, 0, 0, 'h2A, 'b100010)};
      vecs[2]  = '{instr: mk(7, 11, 12, 0, 0),    exp: ex(7, 0, 0, 0, 0, 'h2F, 'b000010)};
      vecs[3]  = '{instr: mk(8, 10, 5, 3, 0),     exp: ex(8, 0, 0, 3, 'hA5, 0, 'b001000)};
      vecs[4]  = '{instr: mk(9, 7, 8, 1, 1),      exp: ex(9, 7, 8, 0, 0, 0, 'b100100)};
      vecs[5]  = '{instr: mk(10, 1, 9, 2, 3),     exp: ex(10, 0, 9, 2, 0, 0, 'b011000)};
      vecs[6]  = '{instr: mk(5, 6, 3, 6, 1),      exp: ex(5, 6, 0, 6, 0, 0, 'b101000)};
      vecs[7]  = '{instr: mk(15, 3, 3, 3, 3),     exp: ex(0, 0, 0, 0, 0, 0, 'b000001)};
      vecs[8]  = '{instr: mk(4, 0, 15, 15, 3),    exp: ex(4, 0, 15, 0, 0, 'h3F, 'b100010)};
      vecs[9]  = '{instr: mk(2, 15, 14, 13, 0),   exp: ex(2, 15, 14, 13, 0, 0, 'b101000)};
      vecs[10] = '{instr: mk(6, 2, 2, 9, 0),      exp: ex(6, 2, 0, 9, 0, 0, 'b101000)};
      vecs[11] = '{instr: mk(11, 1, 2, 3, 1),     exp: ex(0, 0, 0, 0, 0, 0, 'b000001)};
      vecs[12] = '{instr: mk(1, 0, 0, 0, 0),      exp: ex(1, 0, 0, 0, 0, 0, 'b101000)};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_fields", 64'(observed()), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", 64'(in_ready), 64'(1));

      // Vector table, one instruction at a time
      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_instr = vecs[i].instr; out_ready = 1'b1;
         @(negedge clk);
         check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(1));
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
         check($sformatf("vec%0d_fields", i), 64'(observed()), 64'(vecs[i].exp));
         check($sformatf("vec%0d_busy_set", i), 64'(busy), 64'(vecs[i].exp.reg_we));
         @(posedge clk); #1;
         wb_valid = vecs[i].exp.reg_we; wb_dst = vecs[i].exp.dst;
         @(posedge clk); #1;
         wb_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_busy_clr", i), 64'(busy), 64'(0));
      end

      // RAW stall on LOADIN r3 -> ADD r3,r1->r4, released by write-back of r3
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = mk(8, 10, 5, 3, 0);
      @(posedge clk); #1;
      in_instr = mk(0, 3, 1, 4, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("raw_stall", 64'(in_ready), 64'(0));
         @(posedge clk); #1;
      end
      wb_valid = 1'b1; wb_dst = 4'd3;
      @(negedge clk);
      check("raw_release", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; wb_valid = 1'b0;
      @(negedge clk);
      check("raw_out", 64'({out_valid, src0, src1, dst}), 64'({1'b1, 4'd3, 4'd1, 4'd4}));
      clear_reg(4);

      // Eight back-to-back JUMPs
      for (int k = 0; k < 8; k++) begin
         int a, b;
         a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15));
         vecs[k % 13].instr = mk(7, a, b, 0, 0);
         jexp[k] = (a * 16 + b) / 4;
         if (k == 0) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1; in_instr = vecs[0].instr;
         end
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k < 7) in_instr = vecs[k + 1].instr;
         else in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("jump%0d", k), 64'({out_valid, is_branch, jmp_addr}),
               64'({1'b1, 1'b1, 6'(jexp[k])}));
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("jump_end", 64'(out_valid), 64'(0));

      // Back-pressure: ADD held four cycles, JUMP waiting behind it
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = mk(0, 1, 2, 5, 0); out_ready = 1'b0;
      @(posedge clk); #1;
      in_instr = mk(7, 1, 2, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_fields", 64'({out_valid, observed()}), 64'({1'b1, ex(0, 1, 2, 5, 0, 0, 'b101000)}));
         check("hold_ready", 64'(in_ready), 64'(0));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("hold_release", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("hold_next", 64'({out_valid, alu_op, jmp_addr}), 64'({1'b1, 4'd7, 6'h04}));
      clear_reg(5);

      // Flush of a held ADD ->r6, then INC r6 goes straight through
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = mk(0, 1, 2, 6, 0); out_ready = 1'b0;
      @(posedge clk); #1;
      in_instr = mk(5, 6, 0, 6, 0); flush = 1'b1;
      @(negedge clk);
      check("flush_no_accept", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("flush_state", 64'({out_valid, busy, in_ready}), 64'({1'b0, 1'b0, 1'b1}));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_inc", 64'({out_valid, alu_op, src0, dst}), 64'({1'b1, 4'd5, 4'd6, 4'd6}));
      clear_reg(6);

      // Reset mid-stream with three pending registers and a held output
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; out_ready = 1'b1;
         in_instr = mk(8, i + 1, 0, (i == 2) ? 7 : i + 1, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("pre_reset", 64'({out_valid, busy}), 64'({1'b1, 1'b1}));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_reset", 64'({out_valid, busy, observed()}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b1; in_instr = mk(0, 1, 2, 7, 0); out_ready = 1'b1;
      @(negedge clk);
      check("post_reset_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear_reg(7);

      // Randomized run against the reference model
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_valid = 1'b0; m_out = '0;
      foreach (m_pend[r]) m_pend[r] = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         int plist[$];
         logic hz, exp_ready, acc, anyp;
         logic eff[16];
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = mk(($urandom_range(0, 5) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10)),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         plist.delete();
         foreach (m_pend[r]) if (m_pend[r]) plist.push_back(r);
         wb_valid = 1'b0;
         if (plist.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid = 1'b1;
            wb_dst   = 4'(plist[$urandom_range(0, plist.size() - 1)]);
         end else if ($urandom_range(0, 7) == 0) begin
            wb_valid = 1'b1;
            wb_dst   = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         ref_dec(in_instr, mf, mra, mrb, mwc);
         foreach (eff[r]) eff[r] = m_pend[r] && !(wb_valid && int'(wb_dst) == r);
         hz = in_valid && ((mra && eff[in_instr[13:10]]) || (mrb && eff[in_instr[9:6]]) ||
                           (mwc && eff[in_instr[5:2]]));
         exp_ready = (!m_valid || out_ready) && !hz && !flush;
         anyp = 1'b0;
         foreach (m_pend[r]) anyp |= m_pend[r];
         check("rnd_out_valid", 64'(out_valid), 64'(m_valid));
         check("rnd_fields", 64'(observed()), 64'(m_valid ? m_out : fields_t'('0)));
         check("rnd_busy", 64'(busy), 64'(anyp));
         check("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
         acc = in_valid && exp_ready;
         foreach (eff[r]) m_pend[r] = eff[r];
         if (flush && m_valid && !out_ready && m_out.reg_we) m_pend[m_out.dst] = 1'b0;
         if (acc && mwc) m_pend[in_instr[5:2]] = 1'b1;
         if (flush) m_valid = 1'b0;
         else if (acc) begin
            m_valid = 1'b1;
            m_out   = mf;
         end else if (out_ready) m_valid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the n-queen datapath core. It sits between instruction fetch and the ALU/register-file/memory stage and splits each instruction word into ALU opcode, register indices, immediate, jump target and control strobes. It generalises field widths and adds a valid/ready handshake, a register scoreboard with RAW/WAW stall, flush, and illegal-opcode flagging. Unused fields are driven to zero, never held.

## Interface
- RA_W, 4, register-index width; register file has 2**RA_W entries
- JADDR_W, 6, jump-target width; legal range 1..RA_W+2
- INSTR_W, derived = 4+3*RA_W+2 (18 at defaults)
- DATA_W, derived = 2*RA_W (8 at defaults), LOADIN immediate width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  INSTR_W  instruction word
- flush  in  1  discard held, not-yet-consumed instruction
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream consumes decoded fields
- alu_op  out  4  opcode field
- src0, src1, dst  out  RA_W each  register indices
- data  out  DATA_W  LOADIN immediate
- jmp_addr  out  JADDR_W  branch/jump target
- sel1, sel2, reg_we, mem_we  out  1 each  datapath strobes
- is_branch  out  1  CHECK, SUPERCHECK or JUMP
- illegal  out  1  opcode not in the shared opcode set
- wb_valid  in  1  register write-back occurring
- wb_dst  in  RA_W  write-back register index
- busy  out  1  any scoreboard bit set

## Operation
- Fields, MSB first: OPC[4], A[RA_W], B[RA_W], C[RA_W], T[2]. Opcode constants come from the shared definitions header.
- ADD/SUB/MUL: src0=A, src1=B, dst=C, sel1=1, reg_we=1; reads A,B; writes C.
- CHECK/SUPERCHECK: src0=A, src1=B, jmp_addr=low JADDR_W bits of {C,T}, sel1=1; reads A,B.
- INC/DEC: src0=A, dst=C, sel1=1, reg_we=1; reads A; writes C.
- JUMP: jmp_addr=top JADDR_W bits of {A,B}; no reads/writes.
- LOADIN: data={A,B}, dst=C, reg_we=1; writes C.
- STORE: src0=A, src1=B, sel1=1, mem_we=1; reads A,B.
- LOAD: src1=B, dst=C, sel2=1, reg_we=1; reads B; writes C.
- Any other opcode: illegal=1, all strobes 0, fields 0; passes through as a NOP.
- Every field/strobe not listed for an opcode is 0.
- Scoreboard: 2**RA_W pending bits. A register is pending if its bit is set and not cleared by wb_valid/wb_dst in the same cycle.
- hazard = in_valid and (any read register pending, or write register pending).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready): output register loads decode, out_valid=1; if reg_we, set scoreboard[dst].
- Same-cycle set and wb clear on one index: the set wins.
- wb_valid clears scoreboard[wb_dst]; clearing an already clear bit is a no-op.
- flush: out_valid←0 next cycle. If out_valid & !out_ready & held reg_we, clear scoreboard[held dst]. No accept occurs in a flush cycle.
- Output register holds while out_valid & !out_ready.

## Timing
- Reset: out_valid=0, all decoded outputs 0, scoreboard 0, busy=0. in_ready goes high the first cycle after reset deasserts.
- Latency: 1 cycle, accept edge to out_valid.
- Throughput: 1 instruction/cycle with no hazard and out_ready held high.
- A RAW stall releases in the cycle wb_valid matches, with no extra bubble.
- busy is registered and reflects scoreboard state.

## Test plan
- Reset mid-stream with out_valid=1 and 3 pending bits -> all outputs 0, busy=0, in_ready=1 the next cycle.
- LOADIN r3,0xA5 then ADD r3,r1->r4 -> ADD stalls (in_ready=0) until wb_valid/wb_dst=3. It is accepted that cycle and appears with out_valid=1 one cycle later (src0=3, src1=1, dst=4).
- Stream of 8 JUMP words with out_ready=1 -> 8 consecutive out_valid cycles, is_branch=1, jmp_addr equal to the top 6 bits of {A,B}.
- out_ready=0 for 4 cycles with ADD held -> outputs stable, in_ready=0; raising out_ready accepts the next word on that edge.
- flush while ADD ->r6 is held unconsumed -> out_valid=0 next cycle and scoreboard[6] cleared. A following INC r6 is then accepted with no stall.
- Opcode 4'hF -> illegal=1, reg_we=mem_we=0, all fields 0, scoreboard unchanged.
